// File: rtl/morse_msg_sequencer_pkg.sv
// Shared types and defaults for the Morse message sequencer and its letter buffer.
package morse_msg_sequencer_pkg;

  localparam int unsigned LETTER_W        = 3;
  localparam int unsigned IDX_W           = 3;
  localparam int unsigned CNT_W           = 4;
  localparam int unsigned SYM_PER_LET_DEF = 12;
  localparam int unsigned GAP_SYM_DEF     = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP,
    ST_DONE
  } state_e;

endpackage

// File: rtl/morse_msg_sequencer_buf.sv
// Message letter store: one synchronous write port, one asynchronous read port, no reset.
module morse_msg_buf
  import morse_msg_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [IDX_W-1:0]    waddr_i,
  input  logic [LETTER_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]    raddr_i,
  output logic [LETTER_W-1:0] rdata_o
);

  logic [LETTER_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/morse_msg_sequencer.sv
// Plays a stored message letter by letter through an external Morse encoder,
// aligning each letter to a symbol tick and inserting silent gaps between letters.
module morse_msg_sequencer
  import morse_msg_sequencer_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 8,
  parameter int unsigned SYM_PER_LET = SYM_PER_LET_DEF,
  parameter int unsigned GAP_SYM     = GAP_SYM_DEF
) (
  input  logic                ClockIn,
  input  logic                Reset,
  input  logic                WrEn,
  input  logic [IDX_W-1:0]    WrAddr,
  input  logic [LETTER_W-1:0] WrLetter,
  input  logic [CNT_W-1:0]    MsgLen,
  input  logic                Go,
  input  logic                Abort,
  input  logic                SymTick,
  input  logic                EncDotDash,
  output logic                EncStart,
  output logic [LETTER_W-1:0] EncLetter,
  output logic                MorseOut,
  output logic [IDX_W-1:0]    LetterIdx,
  output logic                Busy,
  output logic                Done
);

  localparam logic [CNT_W-1:0] MAX_LEN_C  = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] SYM_LAST_C = CNT_W'(SYM_PER_LET);
  localparam logic [CNT_W-1:0] GAP_LAST_C = CNT_W'(GAP_SYM - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic               last_letter;
  logic               wr_en;

  // Writes are locked out while a message is in flight so playback cannot be corrupted.
  assign wr_en       = WrEn & ~Busy;
  assign last_letter = ({1'b0, idx_q} == (len_q - CNT_W'(1)));

  morse_msg_buf #(
    .DEPTH (MAX_LEN)
  ) u_buf (
    .clk_i   (ClockIn),
    .we_i    (wr_en),
    .waddr_i (WrAddr),
    .wdata_i (WrLetter),
    .raddr_i (idx_q),
    .rdata_o (EncLetter)
  );

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    if (Abort) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Go) begin
            len_d   = (MsgLen > MAX_LEN_C) ? MAX_LEN_C : MsgLen;
            idx_d   = '0;
            cnt_d   = '0;
            state_d = (MsgLen == '0) ? ST_DONE : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (SymTick) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end
        end
        ST_WAIT: begin
          // The tick after the last shifted bit ends the letter; cnt saturates there.
          if (SymTick) begin
            if (cnt_q == SYM_LAST_C) begin
              state_d = last_letter ? ST_DONE : ST_GAP;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_GAP: begin
          if (SymTick) begin
            if (cnt_q == GAP_LAST_C) begin
              state_d = ST_ISSUE;
              idx_d   = idx_q + IDX_W'(1);
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    EncStart  = (state_q != ST_WAIT);
    MorseOut  = EncDotDash & (state_q == ST_WAIT);
    Busy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_GAP);
    Done      = (state_q == ST_DONE);
    LetterIdx = idx_q;
  end

endmodule

// File: tb/tb_morse_msg_sequencer.sv
// Directed bench for morse_msg_sequencer with a behavioural 12-symbol letter encoder on the same tick.
module tb_morse_msg_sequencer;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       WrEn = 1'b0;
  logic [2:0] WrAddr = '0;
  logic [2:0] WrLetter = '0;
  logic [3:0] MsgLen = '0;
  logic       Go = 1'b0;
  logic       Abort = 1'b0;
  logic       SymTick = 1'b0;
  logic       EncDotDash = 1'b0;
  logic       EncStart;
  logic [2:0] EncLetter;
  logic       MorseOut;
  logic [2:0] LetterIdx;
  logic       Busy;
  logic       Done;

  int n_chk = 0;
  int n_fail = 0;
  int phase = 0;

  logic       rec_mo   [600];
  logic       rec_es   [600];
  logic       rec_busy [600];
  logic       rec_done [600];
  logic [2:0] rec_idx  [600];
  logic [2:0] rec_let  [600];

  logic [11:0] enc_sh = '0;

  morse_msg_sequencer dut (
    .ClockIn    (clk),
    .Reset      (Reset),
    .WrEn       (WrEn),
    .WrAddr     (WrAddr),
    .WrLetter   (WrLetter),
    .MsgLen     (MsgLen),
    .Go         (Go),
    .Abort      (Abort),
    .SymTick    (SymTick),
    .EncDotDash (EncDotDash),
    .EncStart   (EncStart),
    .EncLetter  (EncLetter),
    .MorseOut   (MorseOut),
    .LetterIdx  (LetterIdx),
    .Busy       (Busy),
    .Done       (Done)
  );

  always #5 clk = ~clk;

  // dot = 10, dash = 1110, left-aligned and zero padded to 12 symbols
  function automatic logic [11:0] pat(input logic [2:0] l);
    case (l)
      3'd0:    pat = 12'b1011_1000_0000; // A .-
      3'd1:    pat = 12'b1110_1010_1000; // B -...
      3'd2:    pat = 12'b1110_1011_1010; // C -.-.
      3'd3:    pat = 12'b1110_1010_0000; // D -..
      3'd4:    pat = 12'b1000_0000_0000; // E .
      3'd5:    pat = 12'b1010_1110_1000; // F ..-.
      3'd6:    pat = 12'b1110_1110_1000; // G --.
      default: pat = 12'b1010_1010_0000; // H ....
    endcase
  endfunction

  always @(posedge clk) begin
    if (EncStart) begin
      enc_sh     <= pat(EncLetter);
      EncDotDash <= 1'b0;
    end else if (SymTick) begin
      EncDotDash <= enc_sh[11];
      enc_sh     <= {enc_sh[10:0], 1'b0};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    phase   = (phase + 1) % 4;
    SymTick = (phase == 3);
  endtask

  task automatic wr(input logic [2:0] a, input logic [2:0] l);
    WrEn = 1'b1; WrAddr = a; WrLetter = l;
    step();
    WrEn = 1'b0;
  endtask

  task automatic start_go(input logic [3:0] len, input logic w, input logic [2:0] a, input logic [2:0] l);
    for (int i = 0; i < 4; i++) if (phase != 0) step();
    MsgLen = len; Go = 1'b1; WrEn = w; WrAddr = a; WrLetter = l;
    step();
    Go = 1'b0; WrEn = 1'b0;
  endtask

  task automatic capture(input int from, input int to);
    for (int t = from; t < to; t++) begin
      rec_mo[t]   = MorseOut;
      rec_es[t]   = EncStart;
      rec_busy[t] = Busy;
      rec_done[t] = Done;
      rec_idx[t]  = LetterIdx;
      rec_let[t]  = EncLetter;
      step();
    end
  endtask

  function automatic int count_done(input int to);
    int c = 0;
    for (int t = 0; t < to; t++) if (rec_done[t]) c++;
    return c;
  endfunction

  initial begin
    int cnt;
    logic [11:0] p;

    // 1: reset
    step(); step();
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_encstart", 32'(EncStart), 1);
    chk("rst_morse", 32'(MorseOut), 0);
    chk("rst_idx", 32'(LetterIdx), 0);
    Reset = 1'b0;

    // 2: single letter E
    wr(3'd0, 3'd4);
    start_go(4'd1, 1'b0, 3'd0, 3'd0);
    capture(0, 70);
    chk("e_es_issue", 32'(rec_es[2]), 1);
    chk("e_es_wait", 32'(rec_es[3]), 0);
    chk("e_mo_pre", 32'(rec_mo[6]), 0);
    chk("e_mo_first", 32'(rec_mo[7]), 1);
    chk("e_mo_last", 32'(rec_mo[10]), 1);
    chk("e_mo_post", 32'(rec_mo[11]), 0);
    cnt = 0;
    for (int t = 0; t < 70; t++) if (rec_mo[t]) cnt++;
    chk("e_mo_high_cycles", 32'(cnt), 4);
    chk("e_done_pre", 32'(rec_done[54]), 0);
    chk("e_busy_pre", 32'(rec_busy[54]), 1);
    chk("e_done", 32'(rec_done[55]), 1);
    chk("e_busy_at_done", 32'(rec_busy[55]), 0);
    chk("e_done_after", 32'(rec_done[56]), 0);
    chk("e_done_count", 32'(count_done(70)), 1);

    // 3: A,B,C with the A written in the Go cycle
    wr(3'd1, 3'd1);
    wr(3'd2, 3'd2);
    start_go(4'd3, 1'b1, 3'd0, 3'd0);
    capture(0, 200);
    for (int l = 0; l < 3; l++) begin
      chk("abc_letter", 32'(rec_let[3 + 68 * l]), 32'(l));
      chk("abc_idx", 32'(rec_idx[3 + 68 * l]), 32'(l));
      p = pat(3'(l));
      for (int j = 0; j < 12; j++) begin
        chk("abc_symbol", 32'(rec_mo[8 + 68 * l + 4 * j]), 32'(p[11 - j]));
      end
    end
    for (int l = 0; l < 2; l++) begin
      cnt = 0;
      for (int t = 55 + 68 * l; t <= 70 + 68 * l; t++) if (rec_mo[t]) cnt++;
      chk("abc_gap_silent", 32'(cnt), 0);
    end
    chk("abc_done", 32'(rec_done[191]), 1);
    chk("abc_done_count", 32'(count_done(200)), 1);

    // 4: abort on the 6th WAIT tick of B
    start_go(4'd3, 1'b0, 3'd0, 3'd0);
    capture(0, 94);
    chk("ab_pre_idx", 32'(LetterIdx), 1);
    chk("ab_pre_morse", 32'(MorseOut), 1);
    chk("ab_pre_tick", 32'(SymTick), 1);
    Abort = 1'b1;
    step();
    Abort = 1'b0;
    chk("ab_morse", 32'(MorseOut), 0);
    chk("ab_encstart", 32'(EncStart), 1);
    chk("ab_busy", 32'(Busy), 0);
    chk("ab_idx", 32'(LetterIdx), 0);
    chk("ab_done", 32'(Done), 0);
    capture(0, 100);
    chk("ab_no_done", 32'(count_done(100)), 0);

    // 5a: Go and WrEn while busy are dropped
    start_go(4'd3, 1'b0, 3'd0, 3'd0);
    capture(0, 20);
    Go = 1'b1; WrEn = 1'b1; WrAddr = 3'd2; WrLetter = 3'd7;
    capture(20, 21);
    Go = 1'b0; WrEn = 1'b0;
    capture(21, 200);
    chk("bz_letter2", 32'(rec_let[139]), 2);
    p = pat(3'd2);
    for (int j = 0; j < 12; j++) chk("bz_symbol", 32'(rec_mo[144 + 4 * j]), 32'(p[11 - j]));
    chk("bz_done", 32'(rec_done[191]), 1);
    chk("bz_done_count", 32'(count_done(200)), 1);

    // 5b: empty message
    start_go(4'd0, 1'b0, 3'd0, 3'd0);
    capture(0, 8);
    chk("z_done", 32'(rec_done[0]), 1);
    chk("z_busy", 32'(rec_busy[0]), 0);
    chk("z_done_after", 32'(rec_done[1]), 0);
    cnt = 0;
    for (int t = 0; t < 8; t++) if (rec_es[t]) cnt++;
    chk("z_encstart_held", 32'(cnt), 8);

    // 5c: MsgLen above the buffer depth is clamped to 8 letters
    for (int a = 3; a < 8; a++) wr(3'(a), 3'(a));
    start_go(4'd12, 1'b0, 3'd0, 3'd0);
    capture(0, 560);
    cnt = 0;
    for (int t = 1; t < 560; t++) if (rec_es[t - 1] && !rec_es[t]) cnt++;
    chk("max_letters", 32'(cnt), 8);
    for (int l = 0; l < 8; l++) chk("max_letter", 32'(rec_let[3 + 68 * l]), 32'(l));
    chk("max_idx_last", 32'(rec_idx[530]), 7);
    chk("max_done", 32'(rec_done[531]), 1);
    chk("max_busy_at_done", 32'(rec_busy[531]), 0);
    chk("max_done_count", 32'(count_done(560)), 1);

    // 6: reset during the gap after letter 1
    start_go(4'd3, 1'b0, 3'd0, 3'd0);
    capture(0, 126);
    chk("rg_pre_idx", 32'(LetterIdx), 1);
    chk("rg_pre_busy", 32'(Busy), 1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("rg_busy", 32'(Busy), 0);
    chk("rg_done", 32'(Done), 0);
    chk("rg_encstart", 32'(EncStart), 1);
    chk("rg_morse", 32'(MorseOut), 0);
    chk("rg_idx", 32'(LetterIdx), 0);
    chk("rg_letter", 32'(EncLetter), 0);
    start_go(4'd3, 1'b0, 3'd0, 3'd0);
    capture(0, 200);
    chk("rg_new_idx", 32'(rec_idx[3]), 0);
    chk("rg_new_letter", 32'(rec_let[3]), 0);
    chk("rg_new_mo_hi", 32'(rec_mo[8]), 1);
    chk("rg_new_mo_lo", 32'(rec_mo[12]), 0);
    chk("rg_new_done", 32'(rec_done[191]), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
